// File: rtl/trace_frame_sync.sv
// Finds the TPIU full sync (FF,FF,FF,7F) in the captured trace byte stream and assembles sync-aligned frames.
// Optional macro TRACE_SYNC_TIMEOUT_EN: drop back to hunting after TIMEOUT_FRAMES frames without a full sync.
module trace_frame_sync #(
  parameter int FRAME_BYTES    = 16,
  parameter int OVF_CNT_W      = 8,
  parameter int TIMEOUT_FRAMES = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [7:0]               i_in_byte,
  input  logic                     i_in_valid,
  output logic [8*FRAME_BYTES-1:0] o_frame_data,
  output logic                     o_frame_valid,
  input  logic                     i_frame_ready,
  output logic                     o_synced,
  output logic                     o_ovf,
  output logic [OVF_CNT_W-1:0]     o_ovf_cnt
);

  localparam int               CNT_W    = $clog2(FRAME_BYTES);
  localparam int               FRAME_W  = 8 * FRAME_BYTES;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_BYTES - 1);

  typedef enum logic {HUNT = 1'b0, ASSEMBLE = 1'b1} state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [23:0]          r_sync_sr;
  logic [CNT_W-1:0]     r_byte_cnt;
  logic [FRAME_W-9:0]   r_asm;
  logic [FRAME_W-1:0]   r_frame_data;
  logic                 r_frame_valid;
  logic                 r_ovf;
  logic [OVF_CNT_W-1:0] r_ovf_cnt;

  logic               w_match;
  logic               w_store;
  logic               w_complete;
  logic               w_slot_free;
  logic               w_load;
  logic               w_drop;
  logic               w_timeout;
  logic [FRAME_W-1:0] w_frame;

  // The three held bytes plus the byte on the input form the last four bytes of the stream.
  assign w_match     = i_in_valid && ({r_sync_sr, i_in_byte} == 32'hFFFF_FF7F);
  assign w_store     = i_in_valid && (r_state == ASSEMBLE) && !w_match;
  assign w_complete  = w_store && (r_byte_cnt == LAST_IDX);
  assign w_slot_free = !r_frame_valid || i_frame_ready;
  assign w_load      = w_complete && w_slot_free;
  assign w_drop      = w_complete && !w_slot_free;
  assign w_frame     = {i_in_byte, r_asm};

`ifdef TRACE_SYNC_TIMEOUT_EN
  localparam int FC_W = $clog2(TIMEOUT_FRAMES + 1);
  logic [FC_W-1:0] r_frame_cnt;

  assign w_timeout = w_complete && (r_frame_cnt == FC_W'(TIMEOUT_FRAMES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_cnt <= '0;
    end else if (w_match || w_timeout) begin
      r_frame_cnt <= '0;
    end else if (w_complete) begin
      r_frame_cnt <= r_frame_cnt + 1'b1;
    end
  end
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT_FRAMES > 0);
  assign w_timeout        = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= HUNT;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    o_synced    = (r_state == ASSEMBLE);
    if (w_match)        w_state_nxt = ASSEMBLE;
    else if (w_timeout) w_state_nxt = HUNT;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync_sr  <= '0;
      r_byte_cnt <= '0;
    end else if (i_in_valid) begin
      r_sync_sr <= {r_sync_sr[15:0], i_in_byte};
      if (w_match || w_complete) r_byte_cnt <= '0;
      else if (w_store)          r_byte_cnt <= r_byte_cnt + 1'b1;
    end
  end

  // The final byte of a frame goes straight to the output, so the buffer holds FRAME_BYTES-1 bytes.
  always_ff @(posedge clk) begin
    for (int i = 0; i < FRAME_BYTES - 1; i++) begin
      if (w_store && (r_byte_cnt == CNT_W'(i))) r_asm[8*i +: 8] <= i_in_byte;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_data  <= '0;
      r_frame_valid <= 1'b0;
      r_ovf         <= 1'b0;
      r_ovf_cnt     <= '0;
    end else begin
      r_ovf <= w_drop;
      if (w_load) begin
        r_frame_data  <= w_frame;
        r_frame_valid <= 1'b1;
      end else if (r_frame_valid && i_frame_ready) begin
        r_frame_valid <= 1'b0;
      end
      if (w_drop && (r_ovf_cnt != {OVF_CNT_W{1'b1}})) r_ovf_cnt <= r_ovf_cnt + 1'b1;
    end
  end

  assign o_frame_data  = r_frame_data;
  assign o_frame_valid = r_frame_valid;
  assign o_ovf         = r_ovf;
  assign o_ovf_cnt     = r_ovf_cnt;

endmodule

// File: tb/tb_trace_frame_sync.sv
// Directed bench for trace_frame_sync: table of per-byte vectors plus hand-written multi-cycle sequences.
module tb_trace_frame_sync;

  localparam int FB = 16;
  localparam int TO = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [7:0]    in_byte;
  logic          in_valid;
  logic [8*FB-1:0] frame_data;
  logic          frame_valid;
  logic          frame_ready;
  logic          synced;
  logic          ovf;
  logic [7:0]    ovf_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  trace_frame_sync #(
    .FRAME_BYTES(FB),
    .OVF_CNT_W(8),
    .TIMEOUT_FRAMES(TO)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_in_byte    (in_byte),
    .i_in_valid   (in_valid),
    .o_frame_data (frame_data),
    .o_frame_valid(frame_valid),
    .i_frame_ready(frame_ready),
    .o_synced     (synced),
    .o_ovf        (ovf),
    .o_ovf_cnt    (ovf_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         v;
    logic [7:0]   b;
    logic         rdy;
    logic         s;
    logic         fv;
    logic         ov;
    logic         chk_d;
    logic [127:0] d;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic add(input logic v, input logic [7:0] b, input logic rdy, input logic s,
                     input logic fv, input logic chk_d, input logic [127:0] d);
    vec_t e;
    e.v = v; e.b = b; e.rdy = rdy; e.s = s; e.fv = fv; e.ov = 1'b0; e.chk_d = chk_d; e.d = d;
    vq.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    in_valid = 1'b1;
    in_byte  = b;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic send_sync();
    send_byte(8'hFF); send_byte(8'hFF); send_byte(8'hFF); send_byte(8'h7F);
  endtask

  task automatic send_frame(input logic [7:0] base);
    for (int i = 0; i < FB; i++) send_byte(base + 8'(i));
  endtask

  function automatic logic [127:0] mk_frame(input logic [7:0] base);
    logic [127:0] f;
    for (int i = 0; i < FB; i++) f[8*i +: 8] = base + 8'(i);
    return f;
  endfunction

  logic [7:0]   pat4 [4];
  logic [7:0]   t2_bytes [8];
  logic [127:0] exp_a;

  initial begin
    pat4     = '{8'hAA, 8'h55, 8'h66, 8'h99};
    t2_bytes = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF};

    // Test 1: no sync in a 16-byte pattern.
    for (int i = 0; i < 16; i++) add(1, pat4[i % 4], 1, 0, 0, 0, '0);
    // Test 2: sync, then one 16-byte frame accepted immediately.
    for (int i = 0; i < 3; i++) add(1, 8'hFF, 1, 0, 0, 0, '0);
    add(1, 8'h7F, 1, 1, 0, 0, '0);
    for (int i = 0; i < 15; i++) add(1, t2_bytes[i % 8], 1, 1, 0, 0, '0);
    add(1, 8'hEF, 1, 1, 1, 1, 128'hEFCDAB8967452301_EFCDAB8967452301);
    add(0, 8'h00, 1, 1, 0, 0, '0);
    // Test 3: a second sync inside a partial frame restarts assembly.
    for (int i = 0; i < 3; i++) add(1, 8'hFF, 1, 1, 0, 0, '0);
    add(1, 8'h7F, 1, 1, 0, 0, '0);
    add(1, 8'h01, 1, 1, 0, 0, '0);
    add(1, 8'h23, 1, 1, 0, 0, '0);
    for (int i = 0; i < 3; i++) add(1, 8'hFF, 1, 1, 0, 0, '0);
    add(1, 8'h7F, 1, 1, 0, 0, '0);
    for (int i = 0; i < 15; i++) add(1, 8'h10 + 8'(i), 1, 1, 0, 0, '0);
    add(1, 8'h1F, 1, 1, 1, 1, 128'h1F1E1D1C1B1A19181716151413121110);
    add(0, 8'h00, 1, 1, 0, 0, '0);

    rst_n       = 1'b0;
    in_byte     = 8'h00;
    in_valid    = 1'b0;
    frame_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_synced", 128'(synced), 0);
    chk("rst_frame_valid", 128'(frame_valid), 0);
    chk("rst_frame_data", frame_data, 0);
    chk("rst_ovf", 128'(ovf), 0);
    chk("rst_ovf_cnt", 128'(ovf_cnt), 0);
    rst_n = 1'b1;

    for (int k = 0; k < vq.size(); k++) begin
      in_valid    = vq[k].v;
      in_byte     = vq[k].b;
      frame_ready = vq[k].rdy;
      tick();
      chk($sformatf("vec%0d_synced", k), 128'(synced), 128'(vq[k].s));
      chk($sformatf("vec%0d_frame_valid", k), 128'(frame_valid), 128'(vq[k].fv));
      chk($sformatf("vec%0d_ovf", k), 128'(ovf), 128'(vq[k].ov));
      if (vq[k].chk_d) chk($sformatf("vec%0d_frame_data", k), frame_data, vq[k].d);
    end
    in_valid = 1'b0;

    // Test 4: output held while not ready; later frames dropped and counted.
    rst_n = 1'b0;
    tick();
    rst_n       = 1'b1;
    frame_ready = 1'b0;
    exp_a       = mk_frame(8'h10);
    send_sync();
    send_frame(8'h10);
    chk("t4_a_valid", 128'(frame_valid), 1);
    chk("t4_a_data", frame_data, exp_a);
    chk("t4_a_ovf", 128'(ovf), 0);
    send_frame(8'h20);
    chk("t4_b_ovf", 128'(ovf), 1);
    chk("t4_b_ovf_cnt", 128'(ovf_cnt), 1);
    chk("t4_b_held", frame_data, exp_a);
    tick();
    chk("t4_b_ovf_pulse_end", 128'(ovf), 0);
    send_frame(8'h30);
    chk("t4_c_ovf", 128'(ovf), 1);
    chk("t4_c_ovf_cnt", 128'(ovf_cnt), 2);
    chk("t4_c_held", frame_data, exp_a);
    chk("t4_c_valid", 128'(frame_valid), 1);
    tick();
    chk("t4_c_ovf_pulse_end", 128'(ovf), 0);
    frame_ready = 1'b1;
    tick();
    frame_ready = 1'b0;
    chk("t4_accept_valid", 128'(frame_valid), 0);
    tick();
    chk("t4_after_accept_valid", 128'(frame_valid), 0);
    chk("t4_final_ovf_cnt", 128'(ovf_cnt), 2);

    // Test 5: asynchronous reset in the middle of a frame.
    send_sync();
    send_frame(8'h40);
    chk("t5_pre_valid", 128'(frame_valid), 1);
    for (int i = 0; i < 7; i++) send_byte(8'h50 + 8'(i));
    #3;
    rst_n = 1'b0;
    #1;
    chk("t5_async_synced", 128'(synced), 0);
    chk("t5_async_valid", 128'(frame_valid), 0);
    chk("t5_async_data", frame_data, 0);
    chk("t5_async_ovf_cnt", 128'(ovf_cnt), 0);
    tick();
    rst_n = 1'b1;
    frame_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      send_byte(8'h60 + 8'(i));
      chk($sformatf("t5_post_valid%0d", i), 128'(frame_valid), 0);
    end
    chk("t5_post_synced", 128'(synced), 0);

    // Test 6: sync then four back-to-back frames with the consumer always ready.
    send_sync();
    for (int k = 0; k < 4; k++) begin
      send_frame(8'(k * 32));
`ifdef TRACE_SYNC_TIMEOUT_EN
      chk($sformatf("t6_f%0d_valid", k), 128'(frame_valid), 128'(k < TO));
      chk($sformatf("t6_f%0d_synced", k), 128'(synced), 128'(k < TO - 1));
      if (k < TO) chk($sformatf("t6_f%0d_data", k), frame_data, mk_frame(8'(k * 32)));
`else
      chk($sformatf("t6_f%0d_valid", k), 128'(frame_valid), 1);
      chk($sformatf("t6_f%0d_synced", k), 128'(synced), 1);
      chk($sformatf("t6_f%0d_data", k), frame_data, mk_frame(8'(k * 32)));
`endif
    end
    tick();
    chk("t6_end_valid", 128'(frame_valid), 0);
    chk("t6_ovf_cnt", 128'(ovf_cnt), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
